mem_arbiter: RTL

Two-master arbiter that shares the single-port synchronous on-chip SRAM (1-cycle registered read) between the CPU and a second bus master such as a DMA or loader engine. It sits between both masters and the SRAM macro. Each cycle it grants at most one access using round-robin priority, drives the SRAM port, and returns a one-cycle acknowledge with read data. A build option adds bus locking for atomic read-modify-write sequences.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of a single-port synchronous SRAM
// with a 1-cycle registered read.
//
// Optional feature: define ARB_LOCK_EN to add m0_lock/m1_lock bus locking for atomic
// read-modify-write sequences. Without it the arbiter is pure round-robin.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req/we/addr/wdata      master N access request (held until mN_ack)
//   mN_lock                   master N bus lock request (ARB_LOCK_EN only)
//   mN_ack, mN_rdata          one-cycle completion pulse; read data valid with ack
//   mem_en/we/addr/wdata      SRAM command port, driven from the granted master
//   mem_rdata                 SRAM registered read data (valid the cycle after mem_en)
module mem_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
`ifdef ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic r_last;          // 1: m1 was granted most recently
  logic r_ack0, r_ack1;  // set in the cycle after an issue; doubles as ack-cycle exclusion
  logic w_own0, w_own1;  // lock ownership
  logic w_elig0, w_elig1;
  logic w_gnt0, w_gnt1;

`ifdef ARB_LOCK_EN
  logic r_own0, r_own1;

  // Ownership is taken when issued with lock high and kept only while lock stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own0 <= 1'b0;
      r_own1 <= 1'b0;
    end else begin
      r_own0 <= m0_lock & (r_own0 | w_gnt0);
      r_own1 <= m1_lock & (r_own1 | w_gnt1);
    end
  end

  assign w_own0 = r_own0;
  assign w_own1 = r_own1;
`else
  assign w_own0 = 1'b0;
  assign w_own1 = 1'b0;
`endif

  // rst gates eligibility so nothing is issued while reset is held.
  assign w_elig0 = m0_req & ~r_ack0 & ~w_own1 & ~rst;
  assign w_elig1 = m1_req & ~r_ack1 & ~w_own0 & ~rst;

  // On contention the master not granted most recently wins.
  assign w_gnt0 = w_elig0 & (~w_elig1 | r_last);
  assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_last);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
    end else begin
      r_ack0 <= w_gnt0;
      r_ack1 <= w_gnt1;
      if (w_gnt0 | w_gnt1) begin
        r_last <= w_gnt1;
      end
    end
  end

  assign m0_ack   = r_ack0;
  assign m1_ack   = r_ack1;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule
